// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared execute-stage encodings for the store-multiple sequencer
package exec_pkg;

  // Addressing modes: increment/decrement, after/before
  typedef enum logic [1:0] {
    MODE_IA = 2'd0,
    MODE_IB = 2'd1,
    MODE_DA = 2'd2,
    MODE_DB = 2'd3
  } stm_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_XFER   = 2'd2,
    ST_FINISH = 2'd3
  } stm_state_e;

  // Register select meaning "no register"
  localparam logic [3:0] REG_NONE = 4'hF;

endpackage

// File: rtl/reg_count.sv
// rtl/reg_count.sv - combinational population count of a 15-bit register list
module reg_count (
  input  logic [14:0] bits,
  output logic [4:0]  count
);

  // Sum of set bits; 15 bits fit in a 5-bit result
  always_comb begin
    count = '0;
    for (int i = 0; i < 15; i++) begin
      count = count + {4'b0000, bits[i]};
    end
  end

endmodule

// File: rtl/stm_sequencer.sv
// rtl/stm_sequencer.sv - store-multiple sequencer issuing register-list words to data memory
module stm_sequencer
  import exec_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [14:0] reg_list,
  input  logic [31:0] base_addr,
  input  logic [3:0]  base_reg,
  input  logic [1:0]  mode,
  input  logic        writeback,
  output logic [3:0]  sel_rd,
  input  logic [31:0] rd_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        wb_not_enable,
  output logic [3:0]  wb_sel,
  output logic [31:0] wb_data,
  output logic        busy,
  output logic        done
);

  stm_state_e  state_q, state_d;
  logic [14:0] list_q, list_d, list_after, scan;
  logic [31:0] base_q, final_q, final_d, addr_d;
  logic [3:0]  base_reg_q, sel_d, lowest;
  stm_mode_e   mode_q;
  logic        wb_q, load;
  logic [4:0]  count;
  logic [31:0] span;
  logic        wb_ne_d;
  logic [3:0]  wb_sel_d;
  logic [31:0] wb_data_d;

  reg_count u_reg_count (
    .bits  (list_q),
    .count (count)
  );

  // Byte span of the whole transfer: four bytes per listed register
  assign span = {25'd0, count, 2'b00};

  // Working list once the currently selected register has been stored
  assign list_after = list_q & ~(15'd1 << sel_rd);

  assign mem_valid = (state_q == ST_XFER);
  assign mem_wdata = rd_data;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_FINISH);

  // Lowest set bit of the list being scanned, so registers go out in ascending order
  always_comb begin
    scan   = (state_q == ST_XFER) ? list_after : list_q;
    lowest = 4'd0;
    for (int i = 14; i >= 0; i--) begin
      if (scan[i]) lowest = 4'(i);
    end
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state and next values of the registered outputs
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    list_d    = list_q;
    addr_d    = mem_addr;
    final_d   = final_q;
    sel_d     = sel_rd;
    wb_ne_d   = 1'b1;
    wb_sel_d  = REG_NONE;
    wb_data_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          list_d  = reg_list;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        case (mode_q)
          MODE_IA: begin addr_d = base_q;                 final_d = base_q + span; end
          MODE_IB: begin addr_d = base_q + 32'd4;         final_d = base_q + span; end
          MODE_DA: begin addr_d = base_q - span + 32'd4;  final_d = base_q - span; end
          default: begin addr_d = base_q - span;          final_d = base_q - span; end
        endcase
        sel_d = lowest;
        // An empty list still completes, but never writes the base back
        state_d = (count == 5'd0) ? ST_FINISH : ST_XFER;
      end
      ST_XFER: begin
        if (mem_ready) begin
          list_d = list_after;
          addr_d = mem_addr + 32'd4;
          sel_d  = lowest;
          if (list_after == 15'd0) begin
            state_d   = ST_FINISH;
            wb_ne_d   = ~wb_q;
            wb_sel_d  = wb_q ? base_reg_q : REG_NONE;
            wb_data_d = wb_q ? final_q : 32'd0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath registers: latched command, working list, beat address and writeback port
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      list_q        <= '0;
      base_q        <= '0;
      base_reg_q    <= REG_NONE;
      mode_q        <= MODE_IA;
      wb_q          <= 1'b0;
      final_q       <= '0;
      mem_addr      <= '0;
      sel_rd        <= '0;
      wb_not_enable <= 1'b1;
      wb_sel        <= REG_NONE;
      wb_data       <= '0;
    end else begin
      if (load) begin
        base_q     <= base_addr;
        base_reg_q <= base_reg;
        mode_q     <= stm_mode_e'(mode);
        wb_q       <= writeback;
      end
      list_q        <= list_d;
      final_q       <= final_d;
      mem_addr      <= addr_d;
      sel_rd        <= sel_d;
      wb_not_enable <= wb_ne_d;
      wb_sel        <= wb_sel_d;
      wb_data       <= wb_data_d;
    end
  end

endmodule

// File: tb/tb_stm_sequencer.sv
// tb/tb_stm_sequencer.sv - scoreboard bench for the store-multiple sequencer
module tb_stm_sequencer;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    int          cyc;
    logic        wbe;
    logic [3:0]  sel;
    logic [31:0] data;
  } done_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [14:0] reg_list = '0;
  logic [31:0] base_addr = '0;
  logic [3:0]  base_reg = '0;
  logic [1:0]  mode = '0;
  logic        writeback = 1'b0;
  logic        mem_ready = 1'b1;
  logic [3:0]  sel_rd;
  logic [31:0] rd_data;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        wb_not_enable;
  logic [3:0]  wb_sel;
  logic [31:0] wb_data;
  logic        busy;
  logic        done;

  logic [31:0] regs [16];
  logic        tb_we = 1'b0;
  logic [3:0]  tb_sel = '0;
  logic [31:0] tb_data = '0;

  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  beat_t beat_q[$];
  done_t done_q[$];
  beat_t mb;
  done_t md;

  stm_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .reg_list      (reg_list),
    .base_addr     (base_addr),
    .base_reg      (base_reg),
    .mode          (mode),
    .writeback     (writeback),
    .sel_rd        (sel_rd),
    .rd_data       (rd_data),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .wb_not_enable (wb_not_enable),
    .wb_sel        (wb_sel),
    .wb_data       (wb_data),
    .busy          (busy),
    .done          (done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input int i);
    case (i)
      0:       return 32'h0BAD_F00D;
      1:       return 32'h1111_0001;
      2:       return 32'h2222_0002;
      4:       return 32'h4444_0004;
      5:       return 32'h1234_5678;
      6:       return 32'h8765_4321;
      default: return 32'hC0DE_0000 | i;
    endcase
  endfunction

  // Register file model: read port combinational, write port from DUT or bench preload
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= init_val(i);
    end else if (!wb_not_enable) begin
      regs[wb_sel] <= wb_data;
    end else if (tb_we) begin
      regs[tb_sel] <= tb_data;
    end
  end

  assign rd_data = regs[sel_rd];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pop expected beats and completions as the DUT presents them
  always @(negedge clock) begin
    if (!reset) begin
      if (mem_valid && mem_ready) begin
        if (beat_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_beat: got addr %h data %h expected no beat", mem_addr, mem_wdata);
        end else begin
          mb = beat_q.pop_front();
          chk("beat_addr", mem_addr, mb.addr);
          chk("beat_data", mem_wdata, mb.data);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          md = done_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(md.cyc));
          chk("done_wb_ne", {31'd0, wb_not_enable}, {31'd0, ~md.wbe});
          chk("done_wb_sel", {28'd0, wb_sel}, {28'd0, md.sel});
          if (md.wbe) chk("done_wb_data", wb_data, md.data);
          chk("beats_left_at_done", 32'(beat_q.size()), 32'd0);
        end
      end else begin
        chk("idle_wb_ne", {31'd0, wb_not_enable}, 32'd1);
        chk("idle_wb_sel", {28'd0, wb_sel}, 32'hF);
      end
    end
  end

  task automatic push_beat(input logic [31:0] a, input logic [31:0] d);
    beat_t b;
    b.addr = a;
    b.data = d;
    beat_q.push_back(b);
  endtask

  task automatic push_done(input int c, input logic wbe, input logic [3:0] sel, input logic [31:0] d);
    done_t r;
    r.cyc  = c;
    r.wbe  = wbe;
    r.sel  = sel;
    r.data = d;
    done_q.push_back(r);
  endtask

  // Issue one start pulse; returns with the DUT in its first busy cycle
  task automatic launch(input logic [14:0] l, input logic [31:0] b, input logic [3:0] br,
                        input logic [1:0] m, input logic w, output int c_pre);
    reg_list  = l;
    base_addr = b;
    base_reg  = br;
    mode      = m;
    writeback = w;
    start     = 1'b1;
    c_pre     = cyc;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 64) begin
      @(posedge clock);
      #1;
      k++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
    chk("beat_q_drained", 32'(beat_q.size()), 32'd0);
    chk("done_q_drained", 32'(done_q.size()), 32'd0);
  endtask

  initial begin
    int c;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_sel_rd", {28'd0, sel_rd}, 32'd0);
    chk("rst_wb_ne", {31'd0, wb_not_enable}, 32'd1);
    chk("rst_wb_sel", {28'd0, wb_sel}, 32'hF);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    @(posedge clock);
    #1;

    // IA, r0/r5/r6, writeback to r13
    push_beat(32'h1000, 32'h0BAD_F00D);
    push_beat(32'h1004, 32'h1234_5678);
    push_beat(32'h1008, 32'h8765_4321);
    launch(15'h0061, 32'h1000, 4'd13, 2'd0, 1'b1, c);
    push_done(c + 5, 1'b1, 4'd13, 32'h100C);
    wait_idle();

    // DB, r0/r1, writeback to r12
    push_beat(32'h1FF8, 32'h0BAD_F00D);
    push_beat(32'h1FFC, 32'h1111_0001);
    launch(15'h0003, 32'h2000, 4'd12, 2'd3, 1'b1, c);
    push_done(c + 4, 1'b1, 4'd12, 32'h1FF8);
    wait_idle();

    // IB, no writeback
    push_beat(32'h2004, 32'h0BAD_F00D);
    push_beat(32'h2008, 32'h1111_0001);
    launch(15'h0003, 32'h2000, 4'd12, 2'd1, 1'b0, c);
    push_done(c + 4, 1'b0, 4'hF, 32'h0);
    wait_idle();

    // DA, no writeback
    push_beat(32'h1FFC, 32'h0BAD_F00D);
    push_beat(32'h2000, 32'h1111_0001);
    launch(15'h0003, 32'h2000, 4'd12, 2'd2, 1'b0, c);
    push_done(c + 4, 1'b0, 4'hF, 32'h0);
    wait_idle();

    // IA r1/r2/r4 with three stall cycles on the second beat
    push_beat(32'h4000, 32'h1111_0001);
    push_beat(32'h4004, 32'h2222_0002);
    push_beat(32'h4008, 32'h4444_0004);
    launch(15'h0016, 32'h4000, 4'd11, 2'd0, 1'b1, c);
    push_done(c + 8, 1'b1, 4'd11, 32'h400C);
    repeat (2) begin
      @(posedge clock);
      #1;
    end
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("stall_valid", {31'd0, mem_valid}, 32'd1);
      chk("stall_addr", mem_addr, 32'h4004);
      chk("stall_sel", {28'd0, sel_rd}, 32'd2);
      @(posedge clock);
      #1;
    end
    mem_ready = 1'b1;
    wait_idle();

    // Empty list with writeback requested: no beats, no write
    launch(15'h0000, 32'h5000, 4'd7, 2'd0, 1'b1, c);
    push_done(c + 2, 1'b0, 4'hF, 32'h0);
    wait_idle();

    // Base register in the list: original value stored, then updated
    tb_we   = 1'b1;
    tb_sel  = 4'd5;
    tb_data = 32'h3000;
    @(posedge clock);
    #1;
    tb_we = 1'b0;
    push_beat(32'h3000, 32'h3000);
    launch(15'h0020, 32'h3000, 4'd5, 2'd0, 1'b1, c);
    push_done(c + 3, 1'b1, 4'd5, 32'h3004);
    wait_idle();
    chk("base_in_list_r5", regs[5], 32'h3004);

    // Reset while a beat is stalled in XFER
    mem_ready = 1'b0;
    launch(15'h0007, 32'h6000, 4'd9, 2'd0, 1'b1, c);
    @(posedge clock);
    #1;
    @(negedge clock);
    chk("pre_reset_valid", {31'd0, mem_valid}, 32'd1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, mem_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_addr", mem_addr, 32'd0);
    chk("mid_rst_wb_ne", {31'd0, wb_not_enable}, 32'd1);
    repeat (2) @(posedge clock);
    #1;
    reset     = 1'b0;
    mem_ready = 1'b1;
    @(posedge clock);
    #1;

    // Fresh run with a stray start while busy
    push_beat(32'h7000, 32'h0BAD_F00D);
    push_beat(32'h7004, 32'h1111_0001);
    launch(15'h0003, 32'h7000, 4'd10, 2'd0, 1'b1, c);
    push_done(c + 4, 1'b1, 4'd10, 32'h7008);
    @(posedge clock);
    #1;
    reg_list  = 15'h7FFF;
    base_addr = 32'h0;
    base_reg  = 4'd0;
    mode      = 2'd3;
    writeback = 1'b0;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_idle();
    repeat (4) @(posedge clock);
    #1;
    chk("stray_start_idle", {31'd0, busy}, 32'd0);
    chk("stray_r10", regs[10], 32'h7008);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
